// File: rtl/timer_event_dispatch_pkg.sv
// Shared constants for the timer event dispatcher: register map and STATUS layout.
package timer_event_dispatch_pkg;

   typedef enum logic [3:0] {
      REG_MASK_LO = 4'h0,
      REG_MASK_HI = 4'h4,
      REG_LOST    = 4'h8,
      REG_STATUS  = 4'hC
   } reg_addr_e;

   localparam int STATUS_LO_LSB = 0;

   // pend_hi sits directly above the pend_lo field.
   function automatic int status_hi_lsb(input int nb_cores);
      return STATUS_LO_LSB + nb_cores;
   endfunction

endpackage

// File: rtl/timer_event_dispatch_if.sv
// Configuration bus: req/gnt request channel with a one-cycle registered response.
// req is granted in the same cycle (gnt = req); every granted access returns exactly
// one rvalid pulse on the following cycle, with rdata = register value or 0.
interface timer_event_dispatch_if;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/timer_event_dispatch_slot.sv
// One core's pending pair: lo/hi flops, hi-first acknowledge, lost-event reporting.
module timer_event_slot (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       set_lo_i,
   input  logic       set_hi_i,
   input  logic       ack_i,
   output logic       req_o,
   output logic       id_o,
   output logic       pend_lo_o,
   output logic       pend_hi_o,
   output logic [1:0] lost_o
);

   logic pend_lo_q, pend_lo_d;
   logic pend_hi_q, pend_hi_d;
   logic clr_lo, clr_hi;
   logic lost_lo, lost_hi;

   // An ack clears only the bit currently presented on id; a set in the same cycle wins.
   always_comb begin
      clr_hi    = ack_i & pend_hi_q;
      clr_lo    = ack_i & ~pend_hi_q & pend_lo_q;
      pend_lo_d = set_lo_i | (pend_lo_q & ~clr_lo);
      pend_hi_d = set_hi_i | (pend_hi_q & ~clr_hi);
      lost_lo   = set_lo_i & pend_lo_q & ~clr_lo;
      lost_hi   = set_hi_i & pend_hi_q & ~clr_hi;
      lost_o    = {1'b0, lost_lo} + {1'b0, lost_hi};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_lo_q <= 1'b0;
         pend_hi_q <= 1'b0;
      end else begin
         pend_lo_q <= pend_lo_d;
         pend_hi_q <= pend_hi_d;
      end
   end

   assign req_o     = pend_lo_q | pend_hi_q;
   assign id_o      = pend_hi_q;
   assign pend_lo_o = pend_lo_q;
   assign pend_hi_o = pend_hi_q;

endmodule

// File: rtl/timer_event_dispatch.sv
// Fans low/high timer pulses out to masked per-core request lines and counts overruns.
module timer_event_dispatch
   import timer_event_dispatch_pkg::*;
#(
   parameter int NB_CORES  = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                irq_lo_i,
   input  logic                irq_hi_i,
   input  logic                cfg_req_i,
   input  logic                cfg_we_i,
   input  logic [3:0]          cfg_addr_i,
   input  logic [31:0]         cfg_wdata_i,
   output logic                cfg_gnt_o,
   output logic                cfg_rvalid_o,
   output logic [31:0]         cfg_rdata_o,
   output logic [NB_CORES-1:0] irq_req_o,
   output logic [NB_CORES-1:0] irq_id_o,
   input  logic [NB_CORES-1:0] irq_ack_i,
   output logic                busy_o
);

   localparam int SUM_W = CNT_WIDTH + 6;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   timer_event_dispatch_if cfg_if ();

   logic [NB_CORES-1:0]  mask_lo_q, mask_lo_d;
   logic [NB_CORES-1:0]  mask_hi_q, mask_hi_d;
   logic [CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;
   logic                 rvalid_q, rvalid_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [NB_CORES-1:0]  pend_lo, pend_hi;
   logic [1:0]           slot_lost [NB_CORES];
   logic [5:0]           lost_sum;
   logic [SUM_W-1:0]     lost_wide;
   logic [31:0]          status_vec, rd_val;
   logic                 wr_en, rd_en;
   logic                 unused_wdata;

   assign cfg_if.req   = cfg_req_i;
   assign cfg_if.we    = cfg_we_i;
   assign cfg_if.addr  = cfg_addr_i;
   assign cfg_if.wdata = cfg_wdata_i;
   assign cfg_if.gnt   = cfg_if.req;
   assign cfg_if.rvalid = rvalid_q;
   assign cfg_if.rdata = rdata_q;
   assign cfg_gnt_o    = cfg_if.gnt;
   assign cfg_rvalid_o = cfg_if.rvalid;
   assign cfg_rdata_o  = cfg_if.rdata;
   assign unused_wdata = ^cfg_if.wdata[31:NB_CORES];

   for (genvar c = 0; c < NB_CORES; c++) begin : g_slot
      timer_event_slot u_slot (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .set_lo_i  (irq_lo_i & mask_lo_q[c]),
         .set_hi_i  (irq_hi_i & mask_hi_q[c]),
         .ack_i     (irq_ack_i[c]),
         .req_o     (irq_req_o[c]),
         .id_o      (irq_id_o[c]),
         .pend_lo_o (pend_lo[c]),
         .pend_hi_o (pend_hi[c]),
         .lost_o    (slot_lost[c])
      );
   end

   always_comb begin
      wr_en = cfg_if.req & cfg_if.we;
      rd_en = cfg_if.req & ~cfg_if.we;

      status_vec = '0;
      status_vec[STATUS_LO_LSB +: NB_CORES] = pend_lo;
      status_vec[status_hi_lsb(NB_CORES) +: NB_CORES] = pend_hi;

      rd_val = '0;
      case (cfg_if.addr)
         REG_MASK_LO: rd_val = 32'(mask_lo_q);
         REG_MASK_HI: rd_val = 32'(mask_hi_q);
         REG_LOST:    rd_val = 32'(lost_cnt_q);
         REG_STATUS:  rd_val = status_vec;
         default:     rd_val = '0;
      endcase

      mask_lo_d = (wr_en && cfg_if.addr == REG_MASK_LO) ? cfg_if.wdata[NB_CORES-1:0] : mask_lo_q;
      mask_hi_d = (wr_en && cfg_if.addr == REG_MASK_HI) ? cfg_if.wdata[NB_CORES-1:0] : mask_hi_q;

      lost_sum = '0;
      for (int c = 0; c < NB_CORES; c++) begin
         lost_sum = lost_sum + 6'(slot_lost[c]);
      end
      // A clear in the same cycle as new losses keeps only the new losses.
      lost_wide = (wr_en && cfg_if.addr == REG_LOST) ? SUM_W'(lost_sum)
                                                     : SUM_W'(lost_cnt_q) + SUM_W'(lost_sum);
      lost_cnt_d = (lost_wide > SUM_W'(CNT_MAX)) ? CNT_MAX : lost_wide[CNT_WIDTH-1:0];

      rvalid_d = cfg_if.req;
      rdata_d  = rd_en ? rd_val : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mask_lo_q  <= '0;
         mask_hi_q  <= '0;
         lost_cnt_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         mask_lo_q  <= mask_lo_d;
         mask_hi_q  <= mask_hi_d;
         lost_cnt_q <= lost_cnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign busy_o = |{pend_lo, pend_hi};

endmodule

// File: tb/tb_timer_event_dispatch.sv
// Directed bench for timer_event_dispatch; a CNT_WIDTH=4 copy shares all stimulus.
module tb_timer_event_dispatch;

   logic       clk;
   logic       rst;
   logic       irq_lo, irq_hi;
   logic [7:0] irq_ack;
   logic [7:0] irq_req, irq_id;
   logic       busy;
   logic       gnt4, rvalid4, busy4;
   logic [31:0] rdata4;
   logic [7:0] irq_req4, irq_id4;
   logic [31:0] rd, rd4;
   int checks;
   int errors;

   timer_event_dispatch_if bus ();

   timer_event_dispatch #(.NB_CORES(8), .CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst), .irq_lo_i(irq_lo), .irq_hi_i(irq_hi),
      .cfg_req_i(bus.req), .cfg_we_i(bus.we), .cfg_addr_i(bus.addr), .cfg_wdata_i(bus.wdata),
      .cfg_gnt_o(bus.gnt), .cfg_rvalid_o(bus.rvalid), .cfg_rdata_o(bus.rdata),
      .irq_req_o(irq_req), .irq_id_o(irq_id), .irq_ack_i(irq_ack), .busy_o(busy)
   );

   timer_event_dispatch #(.NB_CORES(8), .CNT_WIDTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .irq_lo_i(irq_lo), .irq_hi_i(irq_hi),
      .cfg_req_i(bus.req), .cfg_we_i(bus.we), .cfg_addr_i(bus.addr), .cfg_wdata_i(bus.wdata),
      .cfg_gnt_o(gnt4), .cfg_rvalid_o(rvalid4), .cfg_rdata_o(rdata4),
      .irq_req_o(irq_req4), .irq_id_o(irq_id4), .irq_ack_i(irq_ack), .busy_o(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
      tick();
      bus.req = 1'b0; bus.we = 1'b0; bus.wdata = '0;
      check("wr_rvalid", 32'(bus.rvalid), 32'd1);
      check("wr_rdata", bus.rdata, 32'd0);
   endtask

   task automatic cfg_read(input logic [3:0] a, output logic [31:0] d, output logic [31:0] d4);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
      tick();
      bus.req = 1'b0;
      check("rd_rvalid", 32'(bus.rvalid), 32'd1);
      d  = bus.rdata;
      d4 = rdata4;
   endtask

   task automatic pulse(input logic lo, input logic hi);
      irq_lo = lo; irq_hi = hi;
      tick();
      irq_lo = 1'b0; irq_hi = 1'b0;
   endtask

   task automatic ack(input logic [7:0] a);
      irq_ack = a;
      tick();
      irq_ack = '0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; irq_lo = 1'b0; irq_hi = 1'b0; irq_ack = '0;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_irq_req", 32'(irq_req), 32'h0);
      check("rst_irq_id", 32'(irq_id), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rvalid", 32'(bus.rvalid), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);

      // combinational grant, then one-cycle response
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 4'h0;
      #1 check("gnt_comb", 32'(bus.gnt), 32'h1);
      tick();
      bus.req = 1'b0;
      check("rd_mask_lo_rst_valid", 32'(bus.rvalid), 32'h1);
      check("rd_mask_lo_rst", bus.rdata, 32'h0);
      #1 check("gnt_low", 32'(bus.gnt), 32'h0);
      tick();
      check("rvalid_single", 32'(bus.rvalid), 32'h0);

      // basic lo delivery and ack
      cfg_write(4'h0, 32'h0000_0105);
      cfg_read(4'h0, rd, rd4);
      check("mask_lo_rb", rd, 32'h05);
      pulse(1'b1, 1'b0);
      check("lo_irq_req", 32'(irq_req), 32'h05);
      check("lo_irq_id", 32'(irq_id), 32'h00);
      check("lo_busy", 32'(busy), 32'h1);
      cfg_read(4'hC, rd, rd4);
      check("status_lo", rd, 32'h0005);
      ack(8'h01);
      check("ack0_irq_req", 32'(irq_req), 32'h04);
      ack(8'h02);
      check("ack_idle_ignored", 32'(irq_req), 32'h04);
      ack(8'h04);
      check("ack2_irq_req", 32'(irq_req), 32'h00);
      check("ack2_busy", 32'(busy), 32'h0);

      // lo and hi together, hi first
      cfg_write(4'h0, 32'h01);
      cfg_write(4'h4, 32'h01);
      pulse(1'b1, 1'b1);
      check("both_irq_id", 32'(irq_id), 32'h01);
      check("both_irq_req", 32'(irq_req), 32'h01);
      cfg_read(4'hC, rd, rd4);
      check("status_both", rd, 32'h0101);
      ack(8'h01);
      check("both_ack1_id", 32'(irq_id), 32'h00);
      check("both_ack1_req", 32'(irq_req), 32'h01);
      ack(8'h01);
      check("both_ack2_req", 32'(irq_req), 32'h00);
      check("both_ack2_busy", 32'(busy), 32'h0);
      cfg_read(4'h8, rd, rd4);
      check("lost_zero", rd, 32'h0);

      // unmapped and read-only
      cfg_read(4'h2, rd, rd4);
      check("rd_unmapped", rd, 32'h0);
      cfg_read(4'h4, rd, rd4);
      check("mask_hi_rb", rd, 32'h01);
      cfg_write(4'hC, 32'hFFFF_FFFF);
      cfg_read(4'hC, rd, rd4);
      check("status_ro", rd, 32'h0);

      // set wins over simultaneous ack, no loss counted
      pulse(1'b1, 1'b0);
      irq_lo = 1'b1; irq_ack = 8'h01;
      tick();
      irq_lo = 1'b0; irq_ack = '0;
      check("setwins_req", 32'(irq_req), 32'h01);
      check("setwins_id", 32'(irq_id), 32'h00);
      cfg_read(4'h8, rd, rd4);
      check("setwins_lost", rd, 32'h0);
      pulse(1'b1, 1'b0);
      cfg_read(4'h8, rd, rd4);
      check("lost_one", rd, 32'h1);
      ack(8'h01);
      check("lost_one_ack", 32'(irq_req), 32'h00);
      cfg_write(4'h8, 32'h0);
      cfg_read(4'h8, rd, rd4);
      check("lost_clr", rd, 32'h0);

      // multi-core losses and saturation
      cfg_write(4'h0, 32'h00);
      cfg_write(4'h4, 32'hFF);
      repeat (3) pulse(1'b0, 1'b1);
      cfg_read(4'h8, rd, rd4);
      check("lost16", rd, 32'd16);
      check("lost16_w4", rd4, 32'd15);
      cfg_read(4'hC, rd, rd4);
      check("status_hi", rd, 32'hFF00);
      check("hi_irq_id", 32'(irq_id), 32'hFF);

      // clearing the mask keeps pending bits and blocks new sets
      cfg_write(4'h4, 32'h00);
      check("unmask_keep", 32'(irq_req), 32'hFF);
      pulse(1'b0, 1'b1);
      cfg_read(4'h8, rd, rd4);
      check("unmask_nolost", rd, 32'd16);

      // clear in the same cycle as new losses keeps the increment
      cfg_write(4'h4, 32'hFF);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'h8; irq_hi = 1'b1;
      tick();
      bus.req = 1'b0; bus.we = 1'b0; irq_hi = 1'b0;
      cfg_read(4'h8, rd, rd4);
      check("clr_inc", rd, 32'd8);
      check("clr_inc_w4", rd4, 32'd8);
      repeat (40) pulse(1'b0, 1'b1);
      cfg_read(4'h8, rd, rd4);
      check("lost_sat", rd, 32'd255);
      check("lost_sat_w4", rd4, 32'd15);
      cfg_write(4'h8, 32'h0);
      cfg_read(4'h8, rd, rd4);
      check("lost_clr2", rd, 32'd0);
      check("lost_clr2_w4", rd4, 32'd0);

      // asynchronous reset mid-operation with an access in flight
      cfg_write(4'h0, 32'hFF);
      pulse(1'b1, 1'b0);
      check("pre_rst_req", 32'(irq_req), 32'hFF);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 4'hC;
      tick();
      check("pre_rst_rvalid", 32'(bus.rvalid), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("arst_irq_req", 32'(irq_req), 32'h0);
      check("arst_irq_id", 32'(irq_id), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_rvalid", 32'(bus.rvalid), 32'h0);
      check("arst_rdata", bus.rdata, 32'h0);
      @(posedge clk);
      bus.req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
      cfg_read(4'hC, rd, rd4);
      check("post_rst_status", rd, 32'h0);
      cfg_read(4'h0, rd, rd4);
      check("post_rst_mask_lo", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_event_dispatch.md
TIMER_EVENT_DISPATCH -- requirements
Module: timer_event_dispatch

Interface
REQ-001 SHALL have parameter NB_CORES, default 8, number of destination cores (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of lost-event counter.
REQ-003 SHALL have ports clk_i input 1 (single clock) and rst_i input 1 (reset, asynchronous, active-high).
REQ-004 SHALL have irq_lo_i input 1 (single-cycle pulse, low timer event) and irq_hi_i input 1 (single-cycle pulse, high timer event).
REQ-005 SHALL have cfg_req_i input 1, cfg_we_i input 1 (1=write), cfg_addr_i input 4, cfg_wdata_i input 32, cfg_gnt_o output 1, cfg_rvalid_o output 1, cfg_rdata_o output 32.
REQ-006 SHALL have irq_req_o output NB_CORES (per-core request), irq_id_o output NB_CORES (per-core source, 1=hi, 0=lo), irq_ack_i input NB_CORES (per-core acknowledge).
REQ-007 SHALL have busy_o output 1 (any event pending).

Function
REQ-008 SHALL hold registers MASK_LO (0x0) and MASK_HI (0x4), NB_CORES bits each, bit c enabling delivery to core c.
REQ-009 SHALL hold LOST_CNT (0x8), CNT_WIDTH bits, read-only except writes clear it to 0; STATUS (0xC) read-only = {pend_hi, pend_lo}, pend_lo in the low NB_CORES bits, pend_hi directly above.
REQ-010 SHALL assert cfg_gnt_o combinationally equal to cfg_req_i; a granted access SHALL produce cfg_rvalid_o=1 exactly one cycle later, with cfg_rdata_o = register value for reads and 0 for writes or unmapped addresses; unused upper bits read 0.
REQ-011 SHALL keep per core c two pending flops pend_lo[c], pend_hi[c].
REQ-012 On irq_lo_i=1 at cycle N, SHALL set pend_lo[c] at edge N+1 for every c with MASK_LO[c]=1; same for irq_hi_i with MASK_HI/pend_hi.
REQ-013 irq_req_o[c] SHALL equal pend_lo[c] | pend_hi[c] (visible cycle N+1 after pulse, 1-cycle latency).
REQ-014 irq_id_o[c] SHALL be 1 when pend_hi[c]=1, else 0 (hi has priority).
REQ-015 irq_ack_i[c]=1 with irq_req_o[c]=1 SHALL clear the pending bit selected by irq_id_o[c] in that cycle; irq_ack_i[c] with irq_req_o[c]=0 SHALL be ignored.
REQ-016 Simultaneous set and ack-clear of the same bit SHALL leave the bit set (set wins) and SHALL NOT count as lost.
REQ-017 A set on a bit already 1 and not being cleared that cycle SHALL increment LOST_CNT by 1 per such bit; with multiple bits in one cycle, LOST_CNT SHALL add their count.
REQ-018 LOST_CNT SHALL saturate at 2^CNT_WIDTH-1; a write clear in the same cycle as an increment SHALL yield the increment amount.
REQ-019 Clearing a mask bit SHALL NOT clear an existing pending bit; it only blocks future sets.
REQ-020 irq_lo_i and irq_hi_i high in the same cycle SHALL set both pending bits independently.
REQ-021 busy_o SHALL equal OR of all pending bits.

Reset
REQ-022 rst_i=1 SHALL asynchronously clear MASK_LO, MASK_HI, LOST_CNT, all pending bits, cfg_rvalid_o, cfg_rdata_o; hence irq_req_o, irq_id_o, busy_o = 0.
REQ-023 Reset mid-operation SHALL discard pending events and in-flight config responses; no rvalid SHALL follow deassertion for pre-reset accesses.

Structure
REQ-024 Register offsets and STATUS field layout SHALL be constants in shared package timer_event_dispatch_pkg.
REQ-025 Per-core pending/priority/ack logic SHALL be sub-module timer_event_slot, instantiated NB_CORES times, each reporting a 0-2 lost-event count.

Verification
REQ-026 MASK_LO=0x05, pulse irq_lo_i at N -> irq_req_o=0x05, irq_id_o=0x00 at N+1; ack core 0 -> irq_req_o=0x04 next cycle.
REQ-027 MASK_LO=MASK_HI=0x01, pulse both at N -> irq_id_o[0]=1; ack -> irq_id_o[0]=0, irq_req_o[0]=1; second ack -> irq_req_o[0]=0, busy_o=0.
REQ-028 MASK_HI=0xFF, three hi pulses no acks -> LOST_CNT reads 16; CNT_WIDTH=4, 40 extra pulses -> reads 15; write 0x8 -> reads 0.
REQ-029 Ack core 0 same cycle as new irq_lo_i pulse -> pend_lo[0] stays 1, LOST_CNT unchanged.
REQ-030 Pending on cores 0-7, assert rst_i mid-cycle -> all outputs 0 immediately; STATUS reads 0 after release.
